vbit_rx_buffer: RTL

Receive-side endpoint for the free-running valid-bit/data pipeline: the pipeline stages carry `vbit`/`data` forward every cycle with no backpressure. This block terminates such a chain, absorbs words into a small first-word-fall-through FIFO, and presents them to a consumer over a valid/ready handshake. Words arriving while the FIFO is full are dropped and flagged by a sticky overflow bit. It sits between the last pipeline register stage and any stall-capable consumer, for example a bus-side register interface.

---
 rtl/vbit_pkg.sv | 14 +
 rtl/vbit_rx_buffer_if.sv | 43 ++++
 rtl/vbit_rx_mem.sv | 30 +++
 rtl/vbit_rx_buffer.sv | 103 ++++++++++
 4 files changed

// File: rtl/vbit_pkg.sv
// Shared definitions for the valid-bit receive buffer: default sizes and a
// pointer-width helper used wherever a FIFO index width is derived.
package vbit_pkg;

    localparam int VBIT_WIDTH_DEFAULT    = 20;
    localparam int VBIT_RX_DEPTH_DEFAULT = 4;

    // Index width for a buffer of the given depth. Never returns less than one
    // bit, so a degenerate depth still yields a legal vector.
    function automatic int vbit_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vbit_rx_buffer_if.sv
// Bundle of pipeline-side and consumer-side signals of the receive buffer.
// The buffer connects through the slave modport; whatever drives the pipeline
// word and consumes the head word uses the master modport.
interface vbit_rx_buffer_if
    import vbit_pkg::*;
#(
    parameter int Width = VBIT_WIDTH_DEFAULT,
    parameter int Depth = VBIT_RX_DEPTH_DEFAULT
);
    localparam int CntW = vbit_ptr_w(Depth) + 1;

    logic             vbit_i;
    logic [Width-1:0] data_i;
    logic             valid_o;
    logic [Width-1:0] data_o;
    logic             ready_i;
    logic [CntW-1:0]  count_o;
    logic             ovf_o;
    logic             ovf_clr_i;

    modport slave (
        input  vbit_i,
        input  data_i,
        input  ready_i,
        input  ovf_clr_i,
        output valid_o,
        output data_o,
        output count_o,
        output ovf_o
    );

    modport master (
        output vbit_i,
        output data_i,
        output ready_i,
        output ovf_clr_i,
        input  valid_o,
        input  data_o,
        input  count_o,
        input  ovf_o
    );

endinterface

// File: rtl/vbit_rx_mem.sv
// Depth x Width word storage: synchronous write, asynchronous read.
// Contents are deliberately not reset; occupancy tracking lives in the
// buffer, so stale entries are never observable.
module vbit_rx_mem
    import vbit_pkg::*;
#(
    parameter int Width = VBIT_WIDTH_DEFAULT,
    parameter int Depth = VBIT_RX_DEPTH_DEFAULT,
    parameter int AddrW = vbit_ptr_w(Depth)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write the incoming word into the addressed entry.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vbit_rx_buffer.sv
// Terminates a free-running vbit/data pipeline in a small first-word-fall-
// through FIFO and offers the head word over valid/ready. Words arriving
// while full (and not freed by a same-cycle pop) are dropped and recorded in
// a sticky overflow flag.
module vbit_rx_buffer
    import vbit_pkg::*;
#(
    parameter int Width = VBIT_WIDTH_DEFAULT,
    parameter int Depth = VBIT_RX_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    vbit_rx_buffer_if.slave   bus
);

    localparam int PtrW = vbit_ptr_w(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             valid;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [Width-1:0] head_word;

    // Handshake decode and next-state for pointers, occupancy and overflow.
    // A pop frees a slot in the same cycle, so a full buffer still accepts a
    // word when the consumer takes the head at that edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        valid = (count_q != '0);
        full  = (count_q == CntFull);
        pop   = valid && bus.ready_i;
        push  = bus.vbit_i && (!full || pop);
        drop  = bus.vbit_i && full && !pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; reset discards every buffered word at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    vbit_rx_mem #(
        .Width (Width),
        .Depth (Depth),
        .AddrW (PtrW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_word)
    );

    // Outputs depend on registered state only; data is masked when empty so
    // uninitialised storage never leaks out.
    assign bus.valid_o = valid;
    assign bus.data_o  = valid ? head_word : '0;
    assign bus.count_o = count_q;
    assign bus.ovf_o   = ovf_q;

endmodule
